// File: rtl/map_arbiter.sv
// Single-port wall map RAM shared between the VGA fetch path (priority while busy)
// and three round-robin game ports; rebuilds the default bordered map after reset or on request.
module map_arbiter #(
   parameter int MAP_W = 64,
   parameter int MAP_H = 44
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_vga_busy,
   input  logic [5:0]      i_vga_x,
   input  logic [5:0]      i_vga_y,
   output logic            o_vga_is_wall,
   input  logic            i_init,
   output logic            o_ready,
   output logic            o_init_done,
   input  logic [2:0]      i_req,
   input  logic [2:0][5:0] i_x,
   input  logic [2:0][5:0] i_y,
   input  logic [2:0]      i_we,
   input  logic [2:0]      i_wdata,
   output logic [2:0]      o_gnt,
   output logic [2:0]      o_rvalid,
   output logic            o_rdata
);

   localparam int          DEPTH     = MAP_W * MAP_H;
   localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);
   localparam logic [5:0]  X_LAST    = 6'(MAP_W - 1);
   localparam logic [5:0]  Y_LAST    = 6'(MAP_H - 1);
   localparam logic [5:0]  Y_LIMIT   = 6'(MAP_H);

   typedef enum logic {ST_INIT = 1'b0, ST_SERVE = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [11:0] cnt_q, cnt_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        init_done_d;

   logic        serve_slot;
   logic        found;
   logic [1:0]  gnt_idx;
   logic [1:0]  ord0, ord1, ord2;
   logic        gnt_rd;

   logic [5:0]  acc_x, acc_y;
   logic        acc_we, acc_wdata;
   logic [11:0] acc_addr;
   logic        oob;
   logic        rd;
   logic        border;

   logic        mem [0:DEPTH-1];

   // Game ports only get the RAM in SERVE with the renderer idle; the i_init cycle itself is left empty.
   assign serve_slot = (state_q == ST_SERVE) && !i_vga_busy && !i_init;

   always_comb begin
      ord0 = (ptr_q == 2'd0) ? 2'd1 : (ptr_q == 2'd1) ? 2'd2 : 2'd0;
      ord1 = (ptr_q == 2'd0) ? 2'd2 : (ptr_q == 2'd1) ? 2'd0 : 2'd1;
      ord2 = (ptr_q == 2'd0) ? 2'd0 : (ptr_q == 2'd1) ? 2'd1 : 2'd2;
      found   = 1'b0;
      gnt_idx = 2'd0;
      if (serve_slot) begin
         if (i_req[ord0]) begin
            found   = 1'b1;
            gnt_idx = ord0;
         end else if (i_req[ord1]) begin
            found   = 1'b1;
            gnt_idx = ord1;
         end else if (i_req[ord2]) begin
            found   = 1'b1;
            gnt_idx = ord2;
         end
      end
   end

   assign o_gnt  = found ? (3'b001 << gnt_idx) : 3'b000;
   assign gnt_rd = found && !i_we[gnt_idx];
   assign ptr_d  = found ? gnt_idx : ptr_q;

   assign border = (cnt_q[5:0] == 6'd0) || (cnt_q[5:0] == X_LAST) ||
                   (cnt_q[11:6] == 6'd0) || (cnt_q[11:6] == Y_LAST);

   always_comb begin
      acc_x     = i_vga_x;
      acc_y     = i_vga_y;
      acc_we    = 1'b0;
      acc_wdata = 1'b0;
      if (!i_vga_busy) begin
         if (state_q == ST_INIT) begin
            acc_x     = cnt_q[5:0];
            acc_y     = cnt_q[11:6];
            acc_we    = 1'b1;
            acc_wdata = border;
         end else if (found) begin
            acc_x     = i_x[gnt_idx];
            acc_y     = i_y[gnt_idx];
            acc_we    = i_we[gnt_idx];
            acc_wdata = i_wdata[gnt_idx];
         end
      end
   end

   // Rows past the playfield have no storage: they read as wall and swallow writes.
   assign acc_addr = {acc_y, acc_x};
   assign oob      = (acc_y >= Y_LIMIT);
   assign rd       = oob ? 1'b1 : mem[acc_addr];

   always_ff @(posedge clk) begin
      if (acc_we && !oob) mem[acc_addr] <= acc_wdata;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (!i_vga_busy) begin
               if (cnt_q == LAST_ADDR) begin
                  state_d     = ST_SERVE;
                  cnt_d       = 12'd0;
                  init_done_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
         end
         ST_SERVE: begin
            if (i_init) begin
               state_d = ST_INIT;
               cnt_d   = 12'd0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = 12'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_INIT;
         cnt_q         <= 12'd0;
         ptr_q         <= 2'd2;
         o_init_done   <= 1'b0;
         o_vga_is_wall <= 1'b0;
         o_rvalid      <= 3'b000;
         o_rdata       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         o_init_done <= init_done_d;
         if (i_vga_busy) o_vga_is_wall <= rd;
         o_rvalid <= gnt_rd ? o_gnt : 3'b000;
         if (gnt_rd) o_rdata <= rd;
      end
   end

   assign o_ready = (state_q == ST_SERVE);

endmodule

// File: tb/tb_map_arbiter.sv
// Directed bench for map_arbiter: table of single-cycle arbitration vectors plus
// hand-written sequences for rebuild timing, VGA priority and asynchronous reset.
module tb_map_arbiter;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            i_vga_busy;
   logic [5:0]      i_vga_x, i_vga_y;
   logic            o_vga_is_wall;
   logic            i_init;
   logic            o_ready, o_init_done;
   logic [2:0]      i_req;
   logic [2:0][5:0] i_x, i_y;
   logic [2:0]      i_we, i_wdata;
   logic [2:0]      o_gnt, o_rvalid;
   logic            o_rdata;

   int checks = 0;
   int errors = 0;

   map_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_vga_busy(i_vga_busy), .i_vga_x(i_vga_x), .i_vga_y(i_vga_y),
      .o_vga_is_wall(o_vga_is_wall),
      .i_init(i_init), .o_ready(o_ready), .o_init_done(o_init_done),
      .i_req(i_req), .i_x(i_x), .i_y(i_y), .i_we(i_we), .i_wdata(i_wdata),
      .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic            busy;
      logic [2:0]      req;
      logic [2:0][5:0] x;
      logic [2:0][5:0] y;
      logic [2:0]      we;
      logic [2:0]      wd;
      logic [2:0]      gnt;
      logic [2:0]      rv;
      logic            rd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic b, input logic [2:0] req,
                               input logic [5:0] x0, y0, x1, y1, x2, y2,
                               input logic [2:0] we, wd, gnt, rv, input logic rd);
      vec_t v;
      v.name = n;  v.busy = b;  v.req = req;
      v.x[0] = x0; v.y[0] = y0; v.x[1] = x1; v.y[1] = y1; v.x[2] = x2; v.y[2] = y2;
      v.we = we;   v.wd = wd;   v.gnt = gnt; v.rv = rv;   v.rd = rd;
      return v;
   endfunction

   // Called just after a rising edge: drives one cycle, checks the grant mid-cycle,
   // then checks the registered read response after the closing edge.
   task automatic apply(input vec_t v);
      i_vga_busy = v.busy;
      i_req      = v.req;
      i_x        = v.x;
      i_y        = v.y;
      i_we       = v.we;
      i_wdata    = v.wd;
      #2;
      check({v.name, "_gnt"}, {29'd0, o_gnt}, {29'd0, v.gnt});
      @(posedge clk); #1;
      check({v.name, "_rvalid"}, {29'd0, o_rvalid}, {29'd0, v.rv});
      if (v.rv != 3'b000) check({v.name, "_rdata"}, {31'd0, o_rdata}, {31'd0, v.rd});
      i_req = 3'b000;
   endtask

   // Counts rising edges until o_init_done, bounded.
   task automatic wait_init(input string name);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 6000) begin
         @(posedge clk); #1;
         n++;
         if (o_init_done) done = 1'b1;
      end
      check({name, "_done_seen"}, {31'd0, done}, 32'd1);
      check({name, "_cycles"}, n, 32'd2816);
      check({name, "_ready"}, {31'd0, o_ready}, 32'd1);
      @(posedge clk); #1;
      check({name, "_done_pulse"}, {31'd0, o_init_done}, 32'd0);
   endtask

   initial begin
      int nb, bad_gnt, bad_ready, c;
      bit done;

      rst_n = 1'b0; i_vga_busy = 1'b0; i_vga_x = '0; i_vga_y = '0; i_init = 1'b0;
      i_req = '0; i_x = '0; i_y = '0; i_we = '0; i_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {23'd0, o_vga_is_wall, o_ready, o_init_done, o_gnt, o_rvalid, o_rdata}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", {31'd0, o_ready}, 32'd0);
      #0;
      @(negedge clk);
      check("init_no_gnt", {29'd0, o_gnt}, 32'd0);
      // Re-align to just after a rising edge before counting; the first rebuild edge is already
      // part of the count, so restart from reset at a clean point.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init("init1");

      // Round-robin pointer starts at port 2.
      vecs.push_back(mk("rd_0_5",    0, 3'b001, 0, 5, 0, 0, 0, 0,    3'b000, 3'b000, 3'b001, 3'b001, 1));
      vecs.push_back(mk("rd_10_10",  0, 3'b001, 10, 10, 0, 0, 0, 0,  3'b000, 3'b000, 3'b001, 3'b001, 0));
      vecs.push_back(mk("rr_p1",     0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b010, 3'b010, 1));
      vecs.push_back(mk("rr_p2",     0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b100, 3'b100, 1));
      vecs.push_back(mk("rr_p0",     0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b001, 3'b001, 0));
      vecs.push_back(mk("rr_p1b",    0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b010, 3'b010, 1));
      vecs.push_back(mk("rr_p2b",    0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b100, 3'b100, 1));
      vecs.push_back(mk("rr_p0b",    0, 3'b111, 1, 1, 63, 3, 30, 43, 3'b000, 3'b000, 3'b001, 3'b001, 0));
      vecs.push_back(mk("wr_20_20",  0, 3'b100, 0, 0, 0, 0, 20, 20,  3'b100, 3'b100, 3'b100, 3'b000, 0));
      vecs.push_back(mk("raw_20_20", 0, 3'b001, 20, 20, 0, 0, 0, 0,  3'b000, 3'b000, 3'b001, 3'b001, 1));
      vecs.push_back(mk("rd_oob",    0, 3'b010, 0, 0, 5, 50, 0, 0,   3'b000, 3'b000, 3'b010, 3'b010, 1));
      vecs.push_back(mk("wr_oob",    0, 3'b010, 0, 0, 5, 50, 0, 0,   3'b010, 3'b000, 3'b010, 3'b000, 0));
      vecs.push_back(mk("rd_oob2",   0, 3'b010, 0, 0, 5, 50, 0, 0,   3'b000, 3'b000, 3'b010, 3'b010, 1));
      vecs.push_back(mk("alias_5_6", 0, 3'b100, 0, 0, 0, 0, 5, 6,    3'b000, 3'b000, 3'b100, 3'b100, 0));
      vecs.push_back(mk("idle",      0, 3'b000, 0, 0, 0, 0, 0, 0,    3'b000, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("wr0_20_20", 0, 3'b011, 20, 20, 20, 20, 0, 0, 3'b001, 3'b000, 3'b001, 3'b000, 0));
      vecs.push_back(mk("raw0",      0, 3'b010, 0, 0, 20, 20, 0, 0,  3'b000, 3'b000, 3'b010, 3'b010, 0));
      vecs.push_back(mk("busy_blk",  1, 3'b100, 0, 0, 0, 0, 1, 1,    3'b000, 3'b000, 3'b000, 3'b000, 0));
      vecs.push_back(mk("after_busy",0, 3'b100, 0, 0, 0, 0, 1, 1,    3'b000, 3'b000, 3'b100, 3'b100, 0));
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // VGA wins while busy; the pending port-1 read is granted on the first idle cycle.
      i_vga_x = 6'd0; i_vga_y = 6'd7;
      apply(mk("vga_hold1", 1, 3'b010, 0, 0, 3, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0));
      check("vga_wall_0_7", {31'd0, o_vga_is_wall}, 32'd1);
      i_vga_x = 6'd10; i_vga_y = 6'd10;
      apply(mk("vga_hold2", 1, 3'b010, 0, 0, 3, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0));
      check("vga_wall_10_10", {31'd0, o_vga_is_wall}, 32'd0);
      i_vga_x = 6'd0; i_vga_y = 6'd7;
      apply(mk("busy_fall", 0, 3'b010, 0, 0, 3, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b010, 1));
      check("vga_wall_hold", {31'd0, o_vga_is_wall}, 32'd0);
      i_vga_x = 6'd5; i_vga_y = 6'd50;
      apply(mk("vga_oob", 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0));
      check("vga_wall_oob", {31'd0, o_vga_is_wall}, 32'd1);

      // Dirty a cell so the rebuild is visible afterwards.
      apply(mk("wr1_pre", 0, 3'b100, 0, 0, 0, 0, 20, 20, 3'b100, 3'b100, 3'b100, 3'b000, 0));

      // Rebuild from SERVE with busy toggling every 100 cycles and a request held throughout.
      i_req = 3'b001; i_x[0] = 6'd1; i_y[0] = 6'd1; i_we = '0; i_init = 1'b1; i_vga_busy = 1'b0;
      #2;
      check("init_pulse_gnt", {29'd0, o_gnt}, 32'd0);
      @(posedge clk); #1;
      i_init = 1'b0;
      check("init_ready_low", {31'd0, o_ready}, 32'd0);
      nb = 0; bad_gnt = 0; bad_ready = 0; c = 0; done = 1'b0;
      while (!done && c < 20000) begin
         i_vga_busy = ((c / 100) % 2) == 0;
         #2;
         if (o_gnt != 3'b000) bad_gnt++;
         @(posedge clk); #1;
         if (!i_vga_busy) nb++;
         if (o_init_done) done = 1'b1;
         else if (o_ready) bad_ready++;
         c++;
      end
      check("reinit_done_seen", {31'd0, done}, 32'd1);
      check("reinit_writes", nb, 32'd2816);
      check("reinit_no_gnt", bad_gnt, 32'd0);
      check("reinit_ready_low", bad_ready, 32'd0);
      apply(mk("post_reinit_p0", 0, 3'b001, 1, 1, 0, 0, 0, 0, 3'b000, 3'b000, 3'b001, 3'b001, 0));
      apply(mk("rebuilt_20_20",  0, 3'b010, 0, 0, 20, 20, 0, 0, 3'b000, 3'b000, 3'b010, 3'b010, 0));
      apply(mk("rebuilt_63_10",  0, 3'b100, 0, 0, 0, 0, 63, 10, 3'b000, 3'b000, 3'b100, 3'b100, 1));

      // Asynchronous reset during a read grant: no response, and the rebuild restarts.
      i_vga_busy = 1'b0; i_req = 3'b001; i_x[0] = 6'd0; i_y[0] = 6'd5; i_we = '0;
      #2;
      check("rst_mid_gnt", {29'd0, o_gnt}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {31'd0, o_ready}, 32'd0);
      check("rst_mid_gnt_off", {29'd0, o_gnt}, 32'd0);
      @(posedge clk); #1;
      check("rst_mid_rvalid", {29'd0, o_rvalid}, 32'd0);
      i_req = 3'b000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init("init2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/map_arbiter.md
# map_arbiter

Owns the single-port 64x44 wall map RAM and shares it between the VGA renderer and the game-logic requesters. The VGA fetch path has absolute priority while the renderer is scanning active lines. Three game ports (tank 1, tank 2, shell) are served round-robin during vertical blanking. A built-in sequencer rebuilds the default bordered map after reset or on request.

## Interface
Parameters:
- MAP_W, 64, grid columns
- MAP_H, 44, grid rows (playfield only, status bar excluded)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- i_vga_busy  in  1  renderer is in active lines; map reserved for VGA
- i_vga_x  in  6  VGA fetch column
- i_vga_y  in  6  VGA fetch row
- o_vga_is_wall  out  1  wall bit for the VGA address of the previous cycle
- i_init  in  1  one-cycle pulse: rebuild the default map
- o_ready  out  1  map valid, arbiter in SERVE
- o_init_done  out  1  one-cycle pulse when a rebuild completes
- i_req[2:0]  in  3  request per game port (0 = tank1, 1 = tank2, 2 = shell)
- i_x[p]  in  6  column, per port
- i_y[p]  in  6  row, per port
- i_we[p]  in  1  write enable, per port
- i_wdata[p]  in  1  write data, per port
- o_gnt[2:0]  out  3  one-hot grant, at most one bit per cycle
- o_rvalid[2:0]  out  3  read data valid, one cycle after a read grant
- o_rdata  out  1  read data, shared by all ports, qualified by o_rvalid

## Operation
- Storage is a 2816x1 synchronous single-port array. Address = y*64 + x, 12 bits.
- FSM states: INIT, SERVE.
- After reset the FSM enters INIT. i_init in SERVE also enters INIT. i_init while already in INIT is ignored.
- INIT behaviour:
  - A 12-bit counter walks addresses 0 to 2815.
  - Each cell is written 1 if x==0, x==63, y==0 or y==43; otherwise 0.
  - One write per cycle, only while i_vga_busy=0. The counter holds while busy.
  - After the write to address 2815: o_init_done pulses, the FSM goes to SERVE, and o_ready rises the same cycle.
- SERVE behaviour:
  - With i_vga_busy=1 the RAM reads the VGA address every cycle and no game grants are issued.
  - With i_vga_busy=0, one pending game request is granted per cycle.
  - Grant order is round-robin starting after the last granted port. Reset pointer = port 2, so port 0 wins first.
- Game request rules:
  - A requester holds i_req, address, we and wdata stable until its o_gnt bit is seen.
  - The request is consumed on the grant cycle.
  - Writes commit at the clock edge ending the grant cycle.
  - Reads return o_rdata with o_rvalid[p] exactly one cycle after the grant.
- Out-of-range rows (y >= 44):
  - Reads return 1 (treated as wall).
  - Writes are granted but discarded.
  - Applies to both VGA and game ports.
- o_vga_is_wall is updated only while i_vga_busy=1 and holds otherwise.
- In INIT, o_ready=0 and no game grants are issued. VGA reads are still served; they see the partially rebuilt map.

## Timing
- Reset values:
  - All outputs 0: o_vga_is_wall, o_ready, o_init_done, o_gnt, o_rvalid, o_rdata.
  - Round-robin pointer = 2, init counter = 0, state = INIT.
- VGA latency: address sampled at edge N, wall bit valid after edge N+1.
- Game read latency: grant in cycle N, o_rdata/o_rvalid in cycle N+1.
- i_vga_busy rising in the same cycle as a pending request: VGA wins, no grant, the request stays pending.
- i_vga_busy falling: a grant is possible in the first cycle busy is 0.
- Read-after-write to the same cell by a later grant returns the new value.
- Minimum INIT duration is 2816 non-busy cycles. A rebuild fits in one vertical blank of 45x800 cycles.
- Asynchronous reset mid-INIT or mid-transaction restarts INIT from address 0. No pending o_rvalid is emitted.

## Test plan
- Reset, i_vga_busy=0 -> o_ready rises after 2816 cycles with a one-cycle o_init_done. A read of (0,5) returns 1; a read of (10,10) returns 0.
- Ports 0, 1 and 2 all requesting continuously with busy=0 -> o_gnt sequence 001, 010, 100, 001, ...
- Port 2 writes 1 to (20,20); port 0 then reads (20,20) -> o_rvalid[0] one cycle after its grant, o_rdata=1.
- Port 1 request pending when i_vga_busy rises -> no grant until busy falls. VGA address (0,7) yields o_vga_is_wall=1 one cycle later.
- Read of (5,50) -> o_rdata=1. Write of 0 to (5,50) is discarded and the map is unchanged.
- i_init in SERVE with busy toggling (100 cycles busy, 100 cycles idle) -> exactly 2816 writes occur, none while busy. o_ready stays 0 until done, and no grants are issued during INIT.
